// File: rtl/cp0_ext.sv
// Coprocessor-0 for the multi-cycle MIPS core: SR, Cause, EPC, PRId and the interrupt request.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_ext #(
   parameter int          N_HWINT  = 6,
   parameter logic [31:0] PRID_VAL = 32'h2307_1003,
   parameter logic [5:0]  IM_RST   = 6'b000001
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [29:0]        pc,
   input  logic [31:0]        din,
   input  logic [N_HWINT-1:0] hwint,
   input  logic [4:0]         sel,
   input  logic               wen,
   input  logic               exl_set,
   input  logic               exl_clr,
   input  logic [4:0]         exc_code,
   output logic               int_req,
   output logic [29:0]        epc,
   output logic [31:0]        dout
);

   logic [N_HWINT-1:0] im_q, im_d;
   logic [N_HWINT-1:0] ip_q, ip_d;
   logic               exl_q, exl_d;
   logic               ie_q, ie_d;
   logic [29:0]        epc_q, epc_d;
   logic [4:0]         exc_q, exc_d;
   logic               sr_wr_s, epc_wr_s;
   logic [31:0]        sr_s, cause_s;
   logic               ti_s;

`ifdef CP0_TIMER_EN
   logic [31:0]        count_q, count_d;
   logic [31:0]        compare_q, compare_d;
   logic               ti_q, ti_d;
   logic               count_wr_s, cmp_wr_s;
`endif

   assign sr_wr_s  = wen && (sel == 5'd12);
   assign epc_wr_s = wen && (sel == 5'd14);

   // Next-state: exl_set beats both an SR/EPC write and exl_clr; exl_clr is applied after an SR write.
   always_comb begin
      im_d  = sr_wr_s ? din[10 +: N_HWINT] : im_q;
      exl_d = exl_set | (~exl_clr & (sr_wr_s ? din[1] : exl_q));
      ie_d  = exl_clr | (sr_wr_s ? din[0] : ie_q);
      epc_d = exl_set ? pc : (epc_wr_s ? din[31:2] : epc_q);
      exc_d = exl_set ? exc_code : exc_q;
      ip_d  = hwint;
`ifdef CP0_TIMER_EN
      ip_d[N_HWINT-1] = hwint[N_HWINT-1] | ti_q;
`endif
   end

`ifdef CP0_TIMER_EN
   assign count_wr_s = wen && (sel == 5'd9);
   assign cmp_wr_s   = wen && (sel == 5'd11);

   // Timer next-state: a match on the same edge as a Compare write still leaves TI set.
   always_comb begin
      count_d   = count_wr_s ? din : (count_q + 32'd1);
      compare_d = cmp_wr_s ? din : compare_q;
      ti_d      = ((count_q == compare_q) && (compare_q != 32'd0)) | (ti_q & ~cmp_wr_s);
   end

   // Timer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign ti_s = ti_q;
`else
   assign ti_s = 1'b0;
`endif

   // Architectural CP0 state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         im_q  <= IM_RST[N_HWINT-1:0];
         ip_q  <= {N_HWINT{1'b0}};
         exl_q <= 1'b0;
         ie_q  <= 1'b1;
         epc_q <= 30'd0;
         exc_q <= 5'd0;
      end else begin
         im_q  <= im_d;
         ip_q  <= ip_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         epc_q <= epc_d;
         exc_q <= exc_d;
      end
   end

   assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
   assign epc     = epc_q;

   // Assemble SR and Cause images for MFC0.
   always_comb begin
      sr_s                    = 32'd0;
      sr_s[10 +: N_HWINT]     = im_q;
      sr_s[1]                 = exl_q;
      sr_s[0]                 = ie_q;
      cause_s                 = 32'd0;
      cause_s[10 +: N_HWINT]  = ip_q;
      cause_s[6:2]            = exc_q;
      cause_s[30]             = ti_s;
   end

   // MFC0 read mux; shows pre-edge contents.
   always_comb begin
      case (sel)
         5'd12:   dout = sr_s;
         5'd13:   dout = cause_s;
         5'd14:   dout = {epc_q, 2'b00};
         5'd15:   dout = PRID_VAL;
`ifdef CP0_TIMER_EN
         5'd9:    dout = count_q;
         5'd11:   dout = compare_q;
`endif
         default: dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ext.sv
// Self-checking bench for cp0_ext: directed vector table, corner sequences, randomized run vs. a model.
module tb_cp0_ext;

   logic        clk;
   logic        rst;
   logic [29:0] pc;
   logic [31:0] din;
   logic [5:0]  hwint;
   logic [4:0]  sel;
   logic        wen;
   logic        exl_set;
   logic        exl_clr;
   logic [4:0]  exc_code;
   logic        int_req;
   logic [29:0] epc;
   logic [31:0] dout;

   int n_checks = 0;
   int n_pass   = 0;

   cp0_ext dut (
      .clk(clk), .rst(rst), .pc(pc), .din(din), .hwint(hwint), .sel(sel), .wen(wen),
      .exl_set(exl_set), .exl_clr(exl_clr), .exc_code(exc_code),
      .int_req(int_req), .epc(epc), .dout(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  hw;
      logic        wen;
      logic [4:0]  sel;
      logic [31:0] din;
      logic        set;
      logic        clr;
      logic [29:0] pc;
      logic [4:0]  exc;
      logic [4:0]  rsel;
      logic [31:0] exp_dout;
      logic        exp_int;
      logic [29:0] exp_epc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic [5:0] hw, input logic w, input logic [4:0] s,
                              input logic [31:0] d, input logic st, input logic cl,
                              input logic [29:0] p, input logic [4:0] e, input logic [4:0] rs,
                              input logic [31:0] xd, input logic xi, input logic [29:0] xe);
      vec_t r;
      r.hw = hw; r.wen = w; r.sel = s; r.din = d; r.set = st; r.clr = cl; r.pc = p; r.exc = e;
      r.rsel = rs; r.exp_dout = xd; r.exp_int = xi; r.exp_epc = xe;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic idle_inputs();
      wen = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; sel = 5'd0; din = 32'd0;
      pc = 30'd0; exc_code = 5'd0;
   endtask

   // Leaves the bench at a negedge with rst released.
   task automatic do_reset();
      idle_inputs();
      hwint = 6'd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model state (post-reset values set in the random section).
   logic [5:0]  m_im, m_ip;
   logic        m_exl, m_ie;
   logic [29:0] m_epc;
   logic [4:0]  m_exc;
   logic [31:0] m_count, m_cmp;
   logic        m_ti;

   function automatic logic [31:0] m_read(input logic [4:0] s);
      logic [31:0] r;
      r = 32'd0;
      if (s == 5'd12) r = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      else if (s == 5'd13) begin
         r = (32'(m_ip) << 10) | (32'(m_exc) << 2);
`ifdef CP0_TIMER_EN
         r = r | (32'(m_ti) << 30);
`endif
      end
      else if (s == 5'd14) r = {m_epc, 2'b00};
      else if (s == 5'd15) r = 32'h2307_1003;
`ifdef CP0_TIMER_EN
      else if (s == 5'd9)  r = m_count;
      else if (s == 5'd11) r = m_cmp;
`endif
      return r;
   endfunction

   function automatic logic m_int();
      return (|(m_ip & m_im)) && m_ie && !m_exl;
   endfunction

   initial begin
      logic [4:0] sel_pool[7];
      logic [5:0] n_ip;
      logic       n_ti;
      logic       got;

      rst = 1'b1;
      hwint = 6'd0;
      idle_inputs();
      do_reset();

      // hw, wen, sel, din, set, clr, pc, exc, rsel, exp_dout, exp_int, exp_epc
      tbl.push_back(v(6'h00, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd12, 32'h0000_0401, 0, 30'd0));
      tbl.push_back(v(6'h00, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd13, 32'h0000_0000, 0, 30'd0));
      tbl.push_back(v(6'h00, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd15, 32'h2307_1003, 0, 30'd0));
      tbl.push_back(v(6'h01, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd13, 32'h0000_0400, 1, 30'd0));
      tbl.push_back(v(6'h01, 0, 5'd0,  32'd0,         1, 0, 30'h1004,   5'd0, 5'd12, 32'h0000_0403, 0, 30'h1004));
      tbl.push_back(v(6'h01, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd14, 32'h0000_4010, 0, 30'h1004));
      tbl.push_back(v(6'h01, 0, 5'd0,  32'd0,         0, 1, 30'd0,      5'd0, 5'd12, 32'h0000_0401, 1, 30'h1004));
      tbl.push_back(v(6'h08, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd13, 32'h0000_2000, 0, 30'h1004));
      tbl.push_back(v(6'h08, 1, 5'd12, 32'h0000_2001, 0, 0, 30'd0,      5'd0, 5'd12, 32'h0000_2001, 1, 30'h1004));
      tbl.push_back(v(6'h08, 1, 5'd14, 32'hDEAD_BEEF, 1, 0, 30'h10,     5'd7, 5'd14, 32'h0000_0040, 0, 30'h10));
      tbl.push_back(v(6'h08, 0, 5'd0,  32'd0,         1, 1, 30'h10,     5'd7, 5'd12, 32'h0000_2003, 0, 30'h10));
      tbl.push_back(v(6'h08, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 30'd0,      5'd0, 5'd13, 32'h0000_201C, 0, 30'h10));
      tbl.push_back(v(6'h08, 1, 5'd15, 32'h0000_0000, 0, 0, 30'd0,      5'd0, 5'd15, 32'h2307_1003, 0, 30'h10));
      tbl.push_back(v(6'h08, 0, 5'd0,  32'd0,         0, 0, 30'd0,      5'd0, 5'd20, 32'h0000_0000, 0, 30'h10));
      tbl.push_back(v(6'h08, 1, 5'd12, 32'h0000_2002, 0, 1, 30'd0,      5'd0, 5'd12, 32'h0000_2001, 1, 30'h10));
      tbl.push_back(v(6'h08, 1, 5'd12, 32'hFFFF_FFFF, 0, 0, 30'd0,      5'd0, 5'd12, 32'h0000_FC03, 0, 30'h10));
      tbl.push_back(v(6'h08, 1, 5'd14, 32'h1234_5677, 0, 0, 30'd0,      5'd0, 5'd14, 32'h1234_5674, 0, 30'h048D_159D));

      chk("reset_int_req", {31'd0, int_req}, 32'd0);
      chk("reset_epc", {2'b00, epc}, 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         hwint = tbl[i].hw; wen = tbl[i].wen; sel = tbl[i].sel; din = tbl[i].din;
         exl_set = tbl[i].set; exl_clr = tbl[i].clr; pc = tbl[i].pc; exc_code = tbl[i].exc;
         @(posedge clk);
         #1;
         wen = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; sel = tbl[i].rsel;
         #1;
         chk($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
         chk($sformatf("vec%0d_int", i), {31'd0, int_req}, {31'd0, tbl[i].exp_int});
         chk($sformatf("vec%0d_epc", i), {2'b00, epc}, {2'b00, tbl[i].exp_epc});
         @(negedge clk);
      end

      // Reset while an interrupt is pending and EPC holds a value.
      do_reset();
      hwint = 6'h01; wen = 1'b1; sel = 5'd12; din = 32'h0000_0401;
      @(posedge clk); #1; idle_inputs();
      chk("midrst_pre_int", {31'd0, int_req}, 32'd1);
      @(negedge clk);
      exl_set = 1'b1; pc = 30'h55;
      @(posedge clk); #1; idle_inputs();
      chk("midrst_pre_epc", {2'b00, epc}, 32'h55);
      @(negedge clk);
      exl_clr = 1'b1;
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      rst = 1'b1; hwint = 6'd0;
      @(posedge clk); #1; sel = 5'd12; #1;
      chk("midrst_int", {31'd0, int_req}, 32'd0);
      chk("midrst_epc", {2'b00, epc}, 32'd0);
      chk("midrst_sr", dout, 32'h0000_0401);
      @(negedge clk);
      rst = 1'b0;

`ifdef CP0_TIMER_EN
      do_reset();
      wen = 1'b1; sel = 5'd11; din = 32'd5;
      @(posedge clk); @(negedge clk);
      sel = 5'd9; din = 32'd0;
      @(posedge clk); @(negedge clk);
      sel = 5'd12; din = 32'h0000_8001;
      @(posedge clk); @(negedge clk);
      idle_inputs();
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (int_req) got = 1'b1;
         else begin @(posedge clk); @(negedge clk); end
      end
      chk("timer_int_req", {31'd0, got}, 32'd1);
      sel = 5'd13; #1;
      chk("timer_ti_set", {31'd0, dout[30]}, 32'd1);
      @(negedge clk);
      wen = 1'b1; sel = 5'd11; din = 32'd5;
      @(posedge clk); #1; wen = 1'b0; sel = 5'd13; #1;
      chk("timer_ti_clr", {31'd0, dout[30]}, 32'd0);
      @(negedge clk);
      wen = 1'b1; sel = 5'd9; din = 32'hFFFF_FFFF;
      @(posedge clk); #1; wen = 1'b0; #1;
      chk("count_load", dout, 32'hFFFF_FFFF);
      @(posedge clk); #2;
      chk("count_wrap", dout, 32'd0);
      @(negedge clk);
`endif

      // Randomized run against the reference model.
      do_reset();
      m_im = 6'h01; m_ip = 6'h00; m_exl = 1'b0; m_ie = 1'b1; m_epc = 30'd0; m_exc = 5'd0;
      m_count = 32'd0; m_cmp = 32'd0; m_ti = 1'b0;
      sel_pool[0] = 5'd9;  sel_pool[1] = 5'd11; sel_pool[2] = 5'd12; sel_pool[3] = 5'd13;
      sel_pool[4] = 5'd14; sel_pool[5] = 5'd15; sel_pool[6] = 5'd12;
      for (int c = 0; c < 400; c++) begin
         hwint    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : hwint;
         wen      = ($urandom_range(0, 3) == 0);
         sel      = ($urandom_range(0, 7) == 0) ? 5'($urandom) : sel_pool[$urandom_range(0, 6)];
         din      = $urandom;
         if ($urandom_range(0, 3) == 0) din = {26'd0, din[5:0]};
         exl_set  = ($urandom_range(0, 7) == 0);
         exl_clr  = ($urandom_range(0, 5) == 0);
         pc       = 30'($urandom);
         exc_code = 5'($urandom);
         #1;
         chk($sformatf("rnd%0d_dout_sel%0d", c, sel), dout, m_read(sel));
         chk($sformatf("rnd%0d_int", c), {31'd0, int_req}, {31'd0, m_int()});
         chk($sformatf("rnd%0d_epc", c), {2'b00, epc}, {2'b00, m_epc});
         @(posedge clk);
         n_ip = hwint;
`ifdef CP0_TIMER_EN
         n_ip[5] = n_ip[5] | m_ti;
         n_ti = m_ti;
         if (wen && sel == 5'd11) n_ti = 1'b0;
         if (m_count == m_cmp && m_cmp != 32'd0) n_ti = 1'b1;
         m_count = (wen && sel == 5'd9) ? din : m_count + 32'd1;
         if (wen && sel == 5'd11) m_cmp = din;
         m_ti = n_ti;
`endif
         m_ip = n_ip;
         if (wen && sel == 5'd12) begin m_im = din[15:10]; m_exl = din[1]; m_ie = din[0]; end
         if (wen && sel == 5'd14) m_epc = din[31:2];
         if (exl_clr) begin m_exl = 1'b0; m_ie = 1'b1; end
         if (exl_set) begin m_exl = 1'b1; m_epc = pc; m_exc = exc_code; end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
